// File: rtl/pattern_merge_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pattern_merge_sched
// Description : Two-requester round-robin scheduler in front of a shared,
//               fixed-latency pattern datapath. A granted stimulus vector is
//               registered onto dp_in and the datapath is advanced for LAT
//               cycles. The result is then captured from dp_out and held on
//               the rsp_* channel until the consumer accepts it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   IN_W   width of the stimulus vector (req*_data, dp_in)
//   OUT_W  width of the datapath result (dp_out, rsp_data)
//   LAT    datapath latency in dp_en cycles, 1..15
// Ports
//   blif_clk_net    in   clock, rising edge
//   blif_reset_net  in   synchronous active-low reset
//   req0_valid/req0_data/req0_ready   requester 0 handshake
//   req1_valid/req1_data/req1_ready   requester 1 handshake
//   dp_in   out  vector presented to the datapath
//   dp_en   out  datapath advance enable
//   dp_out  in   datapath result
//   rsp_valid/rsp_ready/rsp_id/rsp_data   result handshake and owner tag
// ============================================================================
module pattern_merge_sched #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 9,
  parameter int unsigned LAT   = 3
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             req0_valid,
  input  logic [IN_W-1:0]  req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [IN_W-1:0]  req1_data,
  output logic             req1_ready,
  output logic [IN_W-1:0]  dp_in,
  output logic             dp_en,
  input  logic [OUT_W-1:0] dp_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [OUT_W-1:0] rsp_data
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_CAPT = 2'd2;
  localparam logic [1:0] c_HOLD = 2'd3;

  // RUN lasts while the counter walks LAT-1 down to 0, i.e. LAT cycles.
  localparam logic [3:0] c_LAT_M1 = 4'(LAT - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [3:0]       r_cnt;
  logic             r_ptr;        // 0: requester 0 wins a tie, 1: requester 1
  logic [IN_W-1:0]  r_dp_in;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [OUT_W-1:0] r_rsp_data;

  logic w_gnt0;
  logic w_gnt1;
  logic w_grant;
  logic w_run_done;
  logic w_rsp_done;

  // --------------------------------------------------------------------------
  // Arbitration: grants exist only in IDLE and only while out of reset, so a
  // request that drops before it is granted leaves no trace.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (blif_reset_net && (r_state == c_IDLE)) begin
      if (req0_valid && req1_valid) begin
        w_gnt0 = ~r_ptr;
        w_gnt1 = r_ptr;
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
  end

  assign w_grant    = w_gnt0 | w_gnt1;
  assign w_run_done = (r_cnt == 4'd0);
  assign w_rsp_done = r_rsp_valid && rsp_ready;

  // --------------------------------------------------------------------------
  // FSM process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant) begin
          w_next_state = c_RUN;
        end
      end
      c_RUN: begin
        if (w_run_done) begin
          w_next_state = c_CAPT;
        end
      end
      c_CAPT: begin
        w_next_state = c_HOLD;
      end
      c_HOLD: begin
        if (w_rsp_done) begin
          w_next_state = c_IDLE;
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    dp_en      = 1'b0;
    case (r_state)
      c_IDLE: begin
        req0_ready = w_gnt0;
        req1_ready = w_gnt1;
      end
      c_RUN: begin
        dp_en = 1'b1;
      end
      default: begin
        dp_en = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers: latch the granted vector and owner, run the latency
  // counter, capture the result and manage the fairness pointer.
  // --------------------------------------------------------------------------
  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      r_cnt       <= 4'd0;
      r_ptr       <= 1'b0;
      r_dp_in     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant) begin
            r_dp_in  <= w_gnt1 ? req1_data : req0_data;
            r_rsp_id <= w_gnt1;
            r_cnt    <= c_LAT_M1;
          end
        end
        c_RUN: begin
          // Saturate at zero; the state leaves RUN on the same edge.
          if (!w_run_done) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        c_CAPT: begin
          r_rsp_data  <= dp_out;
          r_rsp_valid <= 1'b1;
        end
        c_HOLD: begin
          if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            // The requester just served loses the next tie.
            r_ptr       <= ~r_rsp_id;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign dp_in     = r_dp_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_pattern_merge_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pattern_merge_sched
// Description : Directed self-checking bench for pattern_merge_sched. Instance
//               A uses LAT=3, instance B uses LAT=1. Each drives a small
//               behavioural datapath: a LAT-deep pipeline advanced by dp_en
//               computing dp_func(dp_in).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_merge_sched;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (LAT=3)
  logic        rst_a = 1'b0;
  logic        r0v_a = 1'b0, r1v_a = 1'b0, rsp_ready_a = 1'b1;
  logic [10:0] r0d_a = '0, r1d_a = '0;
  logic        r0r_a, r1r_a, dp_en_a, rsp_valid_a, rsp_id_a;
  logic [10:0] dp_in_a;
  logic [8:0]  dp_out_a, rsp_data_a;

  // Instance B (LAT=1)
  logic        rst_b = 1'b0;
  logic        r0v_b = 1'b0, r1v_b = 1'b0, rsp_ready_b = 1'b1;
  logic [10:0] r0d_b = '0, r1d_b = '0;
  logic        r0r_b, r1r_b, dp_en_b, rsp_valid_b, rsp_id_b;
  logic [10:0] dp_in_b;
  logic [8:0]  dp_out_b, rsp_data_b;

  function automatic logic [8:0] dp_func(input logic [10:0] x);
    return x[8:0] ^ {7'd0, x[10:9]} ^ 9'h0C3;
  endfunction

  logic [8:0] pa0 = '0, pa1 = '0, pa2 = '0;
  always @(posedge clk) begin
    if (dp_en_a) begin
      pa0 <= dp_func(dp_in_a);
      pa1 <= pa0;
      pa2 <= pa1;
    end
  end
  assign dp_out_a = pa2;

  logic [8:0] pb0 = '0;
  always @(posedge clk) begin
    if (dp_en_b) pb0 <= dp_func(dp_in_b);
  end
  assign dp_out_b = pb0;

  pattern_merge_sched #(.IN_W(11), .OUT_W(9), .LAT(3)) u_dut_a (
    .blif_clk_net(clk), .blif_reset_net(rst_a),
    .req0_valid(r0v_a), .req0_data(r0d_a), .req0_ready(r0r_a),
    .req1_valid(r1v_a), .req1_data(r1d_a), .req1_ready(r1r_a),
    .dp_in(dp_in_a), .dp_en(dp_en_a), .dp_out(dp_out_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
    .rsp_id(rsp_id_a), .rsp_data(rsp_data_a)
  );

  pattern_merge_sched #(.IN_W(11), .OUT_W(9), .LAT(1)) u_dut_b (
    .blif_clk_net(clk), .blif_reset_net(rst_b),
    .req0_valid(r0v_b), .req0_data(r0d_b), .req0_ready(r0r_b),
    .req1_valid(r1v_b), .req1_data(r1d_b), .req1_ready(r1r_b),
    .dp_in(dp_in_b), .dp_en(dp_en_b), .dp_out(dp_out_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_id(rsp_id_b), .rsp_data(rsp_data_b)
  );

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    r0v_a = 1'b1; r1v_a = 1'b1; r0v_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rsp_valid_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0h expected 0", rsp_valid_a); end
    checks++; if (dp_en_a !== 1'b0) begin errors++; $display("FAIL reset_dp_en: got %0h expected 0", dp_en_a); end
    checks++; if (dp_in_a !== 11'h000) begin errors++; $display("FAIL reset_dp_in: got %0h expected 0", dp_in_a); end
    checks++; if (rsp_data_a !== 9'h000) begin errors++; $display("FAIL reset_rsp_data: got %0h expected 0", rsp_data_a); end
    checks++; if (rsp_id_a !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %0h expected 0", rsp_id_a); end
    checks++; if ({r0r_a, r1r_a} !== 2'b00) begin errors++; $display("FAIL reset_ready_a: got %0b expected 00", {r0r_a, r1r_a}); end
    checks++; if (r0r_b !== 1'b0) begin errors++; $display("FAIL reset_ready_b: got %0h expected 0", r0r_b); end
    @(negedge clk);
    r0v_a = 1'b0; r1v_a = 1'b0; r0v_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single();
    int en_cnt = 0;
    int first  = 0;
    logic [8:0] d = '0;
    logic id = 1'b1;
    @(negedge clk);
    r0d_a = 11'h2A5; r0v_a = 1'b1;
    #1;
    checks++; if ({r0r_a, r1r_a} !== 2'b10) begin errors++; $display("FAIL single_grant: got %0b expected 10", {r0r_a, r1r_a}); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      r0v_a = 1'b0;
      #1;
      if (k == 1) begin
        checks++; if (dp_in_a !== 11'h2A5) begin errors++; $display("FAIL single_dp_in: got %0h expected 2a5", dp_in_a); end
      end
      if (dp_en_a) en_cnt++;
      if (rsp_valid_a && first == 0) begin first = k; d = rsp_data_a; id = rsp_id_a; end
    end
    checks++; if (en_cnt != 3) begin errors++; $display("FAIL single_dp_en_cycles: got %0d expected 3", en_cnt); end
    checks++; if (first != 5) begin errors++; $display("FAIL single_rsp_latency: got %0d expected 5", first); end
    checks++; if (d !== 9'h067) begin errors++; $display("FAIL single_rsp_data: got %0h expected 067", d); end
    checks++; if (id !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %0h expected 0", id); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_contention();
    int ng = 0;
    int nr = 0;
    logic [3:0] gseq = '0;
    logic [3:0] iseq = '0;
    logic [8:0] dseq [4];
    bit both = 1'b0;
    for (int i = 0; i < 4; i++) dseq[i] = '0;
    // Reset first so the pointer favours requester 0 again.
    @(negedge clk); rst_a = 1'b0;
    @(negedge clk); rst_a = 1'b1;
    r0d_a = 11'h111; r1d_a = 11'h3C0; r0v_a = 1'b1; r1v_a = 1'b1; rsp_ready_a = 1'b1;
    for (int c = 0; c < 80 && nr < 4; c++) begin
      #1;
      if (r0r_a && r1r_a) both = 1'b1;
      if (r0r_a || r1r_a) begin
        if (ng < 4) gseq[ng] = r1r_a;
        ng++;
      end
      if (rsp_valid_a && rsp_ready_a) begin
        if (nr < 4) begin iseq[nr] = rsp_id_a; dseq[nr] = rsp_data_a; end
        nr++;
      end
      @(negedge clk);
      if (ng >= 4) begin r0v_a = 1'b0; r1v_a = 1'b0; end
    end
    checks++; if (both) begin errors++; $display("FAIL cont_exclusive: got both readies high expected at most one"); end
    checks++; if (nr != 4) begin errors++; $display("FAIL cont_rsp_count: got %0d expected 4", nr); end
    checks++; if (ng != 4) begin errors++; $display("FAIL cont_grant_count: got %0d expected 4", ng); end
    checks++; if (gseq !== 4'b1010) begin errors++; $display("FAIL cont_grant_order: got %b expected 1010", gseq); end
    checks++; if (iseq !== 4'b1010) begin errors++; $display("FAIL cont_rsp_id_order: got %b expected 1010", iseq); end
    checks++; if (dseq[0] !== 9'h1D2 || dseq[2] !== 9'h1D2) begin errors++; $display("FAIL cont_data_req0: got %0h/%0h expected 1d2", dseq[0], dseq[2]); end
    checks++; if (dseq[1] !== 9'h102 || dseq[3] !== 9'h102) begin errors++; $display("FAIL cont_data_req1: got %0h/%0h expected 102", dseq[1], dseq[3]); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    int w = 0;
    @(negedge clk);
    r1d_a = 11'h0FF; r1v_a = 1'b1; rsp_ready_a = 1'b0;
    #1;
    checks++; if ({r0r_a, r1r_a} !== 2'b01) begin errors++; $display("FAIL bp_grant: got %0b expected 01", {r0r_a, r1r_a}); end
    @(negedge clk);
    r1v_a = 1'b0; r0d_a = 11'h2A5; r0v_a = 1'b1;
    #1;
    while (!rsp_valid_a && w < 20) begin @(negedge clk); #1; w++; end
    checks++; if (rsp_valid_a !== 1'b1) begin errors++; $display("FAIL bp_rsp_arrive: got %0h expected 1", rsp_valid_a); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (rsp_valid_a !== 1'b1 || rsp_data_a !== 9'h03C || rsp_id_a !== 1'b1 || r0r_a !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%0h data=%0h id=%0h ready0=%0h expected 1 03c 1 0", k, rsp_valid_a, rsp_data_a, rsp_id_a, r0r_a);
      end
      @(negedge clk); #1;
    end
    rsp_ready_a = 1'b1;
    #1;
    checks++; if (rsp_valid_a !== 1'b1 || r0r_a !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%0h ready0=%0h expected 1 0", rsp_valid_a, r0r_a); end
    @(negedge clk); #1;
    checks++; if (rsp_valid_a !== 1'b0 || r0r_a !== 1'b1) begin errors++; $display("FAIL bp_next_grant: got valid=%0h ready0=%0h expected 0 1", rsp_valid_a, r0r_a); end
    @(negedge clk);
    r0v_a = 1'b0;
    w = 0; #1;
    while (!rsp_valid_a && w < 20) begin @(negedge clk); #1; w++; end
    checks++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 1'b0 || rsp_data_a !== 9'h067) begin errors++; $display("FAIL bp_waiting_req: got valid=%0h id=%0h data=%0h expected 1 0 067", rsp_valid_a, rsp_id_a, rsp_data_a); end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_run();
    int w = 0;
    bit seen = 1'b0;
    // Pointer favours requester 1 here; a tie after reset must still go to 0.
    @(negedge clk);
    r1d_a = 11'h3C0; r1v_a = 1'b1;
    #1;
    checks++; if (r1r_a !== 1'b1) begin errors++; $display("FAIL rst_run_grant: got %0h expected 1", r1r_a); end
    @(negedge clk);
    r1v_a = 1'b0;
    #1;
    checks++; if (dp_en_a !== 1'b1) begin errors++; $display("FAIL rst_run_dp_en: got %0h expected 1", dp_en_a); end
    @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    checks++;
    if (dp_en_a !== 1'b0 || dp_in_a !== 11'h000 || rsp_valid_a !== 1'b0 || rsp_data_a !== 9'h000 || rsp_id_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_run_outputs: got en=%0h in=%0h valid=%0h data=%0h id=%0h expected all 0", dp_en_a, dp_in_a, rsp_valid_a, rsp_data_a, rsp_id_a);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (rsp_valid_a) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_run_no_rsp: got rsp_valid=1 expected 0"); end
    @(negedge clk);
    r0d_a = 11'h111; r1d_a = 11'h3C0; r0v_a = 1'b1; r1v_a = 1'b1;
    #1;
    checks++; if ({r0r_a, r1r_a} !== 2'b10) begin errors++; $display("FAIL rst_run_ptr: got %0b expected 10", {r0r_a, r1r_a}); end
    @(negedge clk);
    r0v_a = 1'b0; r1v_a = 1'b0;
    #1;
    while (!rsp_valid_a && w < 20) begin @(negedge clk); #1; w++; end
    checks++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 1'b0 || rsp_data_a !== 9'h1D2) begin errors++; $display("FAIL rst_run_after: got valid=%0h id=%0h data=%0h expected 1 0 1d2", rsp_valid_a, rsp_id_a, rsp_data_a); end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_cancel();
    bit g1 = 1'b0;
    int first = 0;
    int w = 0;
    logic id = 1'b1;
    logic [8:0] d = '0;
    @(negedge clk);
    r0d_a = 11'h0FF; r0v_a = 1'b1;
    #1;
    checks++; if (r0r_a !== 1'b1) begin errors++; $display("FAIL cancel_grant0: got %0h expected 1", r0r_a); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      r0v_a = 1'b0;
      r1v_a = (k == 2 || k == 3);
      #1;
      if (r1r_a) g1 = 1'b1;
      if (rsp_valid_a && first == 0) begin first = k; id = rsp_id_a; d = rsp_data_a; end
    end
    checks++; if (g1) begin errors++; $display("FAIL cancel_no_grant1: got ready1=1 expected 0"); end
    checks++; if (first != 5 || id !== 1'b0 || d !== 9'h03C) begin errors++; $display("FAIL cancel_rsp: got at=%0d id=%0h data=%0h expected 5 0 03c", first, id, d); end
    // Only the completed requester-0 transaction moved the pointer: tie goes to 1.
    @(negedge clk);
    r0v_a = 1'b1; r1v_a = 1'b1;
    #1;
    checks++; if ({r0r_a, r1r_a} !== 2'b01) begin errors++; $display("FAIL cancel_ptr: got %0b expected 01", {r0r_a, r1r_a}); end
    @(negedge clk);
    r0v_a = 1'b0; r1v_a = 1'b0;
    #1;
    while (!rsp_valid_a && w < 20) begin @(negedge clk); #1; w++; end
    checks++; if (rsp_valid_a !== 1'b1 || rsp_id_a !== 1'b1) begin errors++; $display("FAIL cancel_after: got valid=%0h id=%0h expected 1 1", rsp_valid_a, rsp_id_a); end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_lat1();
    int en_cnt = 0;
    int first  = 0;
    logic [8:0] d = '0;
    logic id = 1'b1;
    @(negedge clk);
    r0d_b = 11'h111; r0v_b = 1'b1;
    #1;
    checks++; if (r0r_b !== 1'b1) begin errors++; $display("FAIL lat1_grant: got %0h expected 1", r0r_b); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      r0v_b = 1'b0;
      #1;
      if (dp_en_b) en_cnt++;
      if (rsp_valid_b && first == 0) begin first = k; d = rsp_data_b; id = rsp_id_b; end
    end
    checks++; if (en_cnt != 1) begin errors++; $display("FAIL lat1_dp_en_cycles: got %0d expected 1", en_cnt); end
    checks++; if (first != 3) begin errors++; $display("FAIL lat1_rsp_latency: got %0d expected 3", first); end
    checks++; if (d !== 9'h1D2 || id !== 1'b0) begin errors++; $display("FAIL lat1_rsp: got data=%0h id=%0h expected 1d2 0", d, id); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid_run();
    test_cancel();
    test_lat1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
